hazard_stall_unit: RTL and testbench

- Detects pipeline hazards that operand forwarding cannot resolve and stalls or flushes the pipeline to clear them.
- Drives PC/IF_ID write-enables, the ID_EX bubble insert and the IF_ID flush.
- Sits in the ID stage next to the forwarding unit.
- Holds a small stall-extension FSM and saturating stall/flush performance counters.

---
 rtl/hazard_stall_unit_pkg.sv | 22 ++
 rtl/hazard_stall_unit_sat_counter.sv | 36 +++
 rtl/hazard_stall_unit.sv | 121 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the ID-stage hazard/stall unit: FSM encoding,
// the hard-wired zero register and the source-match helper.
package hazard_stall_unit_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXT = 1'b1
    } stall_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when dest feeds rs, or rt when rt is actually read; $0 never matches.
    function automatic logic match_src(
        input logic [4:0] dest,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rt
    );
        return (dest != REG_ZERO) && ((dest == rs) || (use_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module hazard_stall_unit_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection: stalls on hazards forwarding cannot cover,
// flushes IF on taken control transfers, and counts stall/flush cycles.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RegRs,
    input  logic [4:0]       IF_ID_RegRt,
    input  logic             IF_ID_UseRt,
    input  logic             IDControl_Branch,
    input  logic             IDControl_Jr,
    input  logic             IDControl_Jump,
    input  logic             Branch_Taken,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RegRt,
    input  logic [4:0]       ID_EX_RegRd,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_RegRd,
    input  logic             Cnt_Clear,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Flush,
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    stall_state_e state_q;
    stall_state_e state_d;

    logic br;
    logic load_use;
    logic br_alu;
    logic br_load_ex;
    logic br_load_mem;
    logic hz;
    logic stall;

    // Branches compare rs and rt in ID; jr/jalr only read rs.
    assign br          = IDControl_Branch | IDControl_Jr;
    assign load_use    = ID_EX_MemRead &&
                         match_src(ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt, IF_ID_UseRt);
    assign br_alu      = br && ID_EX_RegWrite && !ID_EX_MemRead &&
                         match_src(ID_EX_RegRd, IF_ID_RegRs, IF_ID_RegRt, IDControl_Branch);
    assign br_load_ex  = br && ID_EX_MemRead &&
                         match_src(ID_EX_RegRt, IF_ID_RegRs, IF_ID_RegRt, IDControl_Branch);
    assign br_load_mem = br && EX_MEM_MemRead &&
                         match_src(EX_MEM_RegRd, IF_ID_RegRs, IF_ID_RegRt, IDControl_Branch);
    assign hz          = load_use | br_alu | br_load_ex | br_load_mem;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                stall = hz;
                if (br_load_ex) begin
                    state_d = ST_EXT;
                end
            end
            ST_EXT: begin
                // Second cycle of branch-after-load; MEM inputs are ignored here.
                stall   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // While stalled the branch is unresolved, so the IF flush is held off.
    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        ID_EX_Flush = 1'b0;
        IF_ID_Flush = (IDControl_Branch & Branch_Taken) | IDControl_Jump | IDControl_Jr;
        if (!reset) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            IF_ID_Flush = 1'b1;
        end else if (stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            IF_ID_Flush = 1'b0;
        end
    end

    hazard_stall_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (stall),
        .clr   (Cnt_Clear),
        .count (Stall_Count)
    );

    hazard_stall_unit_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (IF_ID_Flush & reset),
        .clr   (Cnt_Clear),
        .count (Flush_Count)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a 16-bit instance plus a 2-bit
// instance on the same stimulus to exercise counter saturation.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  IF_ID_RegRs, IF_ID_RegRt;
    logic        IF_ID_UseRt;
    logic        IDControl_Branch, IDControl_Jr, IDControl_Jump, Branch_Taken;
    logic        ID_EX_MemRead, ID_EX_RegWrite;
    logic [4:0]  ID_EX_RegRt, ID_EX_RegRd;
    logic        EX_MEM_MemRead;
    logic [4:0]  EX_MEM_RegRd;
    logic        Cnt_Clear;
    logic        PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush;
    logic [15:0] Stall_Count, Flush_Count;
    logic        PC_Write2, IF_ID_Write2, ID_EX_Flush2, IF_ID_Flush2;
    logic [1:0]  Stall_Count2, Flush_Count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt), .IF_ID_UseRt(IF_ID_UseRt),
        .IDControl_Branch(IDControl_Branch), .IDControl_Jr(IDControl_Jr),
        .IDControl_Jump(IDControl_Jump), .Branch_Taken(Branch_Taken),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_RegRt(ID_EX_RegRt), .ID_EX_RegRd(ID_EX_RegRd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_RegRd(EX_MEM_RegRd),
        .Cnt_Clear(Cnt_Clear),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .ID_EX_Flush(ID_EX_Flush), .IF_ID_Flush(IF_ID_Flush),
        .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    hazard_stall_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt), .IF_ID_UseRt(IF_ID_UseRt),
        .IDControl_Branch(IDControl_Branch), .IDControl_Jr(IDControl_Jr),
        .IDControl_Jump(IDControl_Jump), .Branch_Taken(Branch_Taken),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_RegRt(ID_EX_RegRt), .ID_EX_RegRd(ID_EX_RegRd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_RegRd(EX_MEM_RegRd),
        .Cnt_Clear(Cnt_Clear),
        .PC_Write(PC_Write2), .IF_ID_Write(IF_ID_Write2),
        .ID_EX_Flush(ID_EX_Flush2), .IF_ID_Flush(IF_ID_Flush2),
        .Stall_Count(Stall_Count2), .Flush_Count(Flush_Count2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Packs {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush} for one-line checks.
    function automatic logic [31:0] ctl();
        return {28'd0, PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush};
    endfunction

    localparam logic [31:0] CTL_RUN   = 32'b1100;
    localparam logic [31:0] CTL_FLUSH = 32'b1101;
    localparam logic [31:0] CTL_STALL = 32'b0010;
    localparam logic [31:0] CTL_RESET = 32'b0011;

    task automatic idle_inputs();
        IF_ID_RegRs      = 5'd0;
        IF_ID_RegRt      = 5'd0;
        IF_ID_UseRt      = 1'b0;
        IDControl_Branch = 1'b0;
        IDControl_Jr     = 1'b0;
        IDControl_Jump   = 1'b0;
        Branch_Taken     = 1'b0;
        ID_EX_MemRead    = 1'b0;
        ID_EX_RegWrite   = 1'b0;
        ID_EX_RegRt      = 5'd0;
        ID_EX_RegRd      = 5'd0;
        EX_MEM_MemRead   = 1'b0;
        EX_MEM_RegRd     = 5'd0;
        Cnt_Clear        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        idle_inputs();
        Cnt_Clear = 1'b1;
        step();
        Cnt_Clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        #2;
        check("reset_ctl", ctl(), CTL_RESET);
        check("reset_stall_cnt", 32'(Stall_Count), 32'd0);
        check("reset_flush_cnt", 32'(Flush_Count), 32'd0);
        step();
        reset = 1'b1;
        step();
        #1;
        check("idle_ctl", ctl(), CTL_RUN);
        check("idle_flush_cnt", 32'(Flush_Count), 32'd0);

        // lw $8 in EX, add using $8 in ID: one stall cycle.
        clear_counters();
        ID_EX_MemRead = 1'b1; ID_EX_RegRt = 5'd8; IF_ID_RegRs = 5'd8; IF_ID_RegRt = 5'd2;
        IF_ID_UseRt = 1'b1;
        #1;
        check("load_use_ctl", ctl(), CTL_STALL);
        step();
        idle_inputs();
        #1;
        check("load_use_after_ctl", ctl(), CTL_RUN);
        check("load_use_stall_cnt", 32'(Stall_Count), 32'd1);

        // lw $8 in EX, beq $8,$9 in ID: two stalls via EXT.
        clear_counters();
        check("clear_stall_cnt", 32'(Stall_Count), 32'd0);
        ID_EX_MemRead = 1'b1; ID_EX_RegRt = 5'd8; IF_ID_RegRs = 5'd8; IF_ID_RegRt = 5'd9;
        IF_ID_UseRt = 1'b1; IDControl_Branch = 1'b1;
        #1;
        check("br_load_c1_ctl", ctl(), CTL_STALL);
        step();
        ID_EX_MemRead = 1'b0; ID_EX_RegRt = 5'd0;
        EX_MEM_MemRead = 1'b0;
        #1;
        check("br_load_c2_ctl", ctl(), CTL_STALL);
        step();
        #1;
        check("br_load_c3_ctl", ctl(), CTL_RUN);
        check("br_load_stall_cnt", 32'(Stall_Count), 32'd2);

        // add $5 in EX, beq $5,$0 taken: stall, then flush.
        clear_counters();
        ID_EX_RegWrite = 1'b1; ID_EX_RegRd = 5'd5; IF_ID_RegRs = 5'd5; IF_ID_RegRt = 5'd0;
        IDControl_Branch = 1'b1; Branch_Taken = 1'b1;
        #1;
        check("br_alu_c1_ctl", ctl(), CTL_STALL);
        step();
        ID_EX_RegWrite = 1'b0; ID_EX_RegRd = 5'd0;
        #1;
        check("br_alu_c2_ctl", ctl(), CTL_FLUSH);
        step();
        idle_inputs();
        #1;
        check("br_alu_flush_cnt", 32'(Flush_Count), 32'd1);
        check("br_alu_stall_cnt", 32'(Stall_Count), 32'd1);

        // $0 destinations everywhere with matching sources: never a stall.
        clear_counters();
        ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; EX_MEM_MemRead = 1'b1;
        IF_ID_UseRt = 1'b1; IDControl_Branch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("zero_reg_pcw_%0d", i), 32'(PC_Write), 32'd1);
            step();
        end
        idle_inputs();
        #1;
        check("zero_reg_stall_cnt", 32'(Stall_Count), 32'd0);

        // j with no hazard: one-cycle IF flush, no bubble.
        IDControl_Jump = 1'b1;
        #1;
        check("jump_ctl", ctl(), CTL_FLUSH);
        step();
        idle_inputs();
        // ori ignores rt, so a load matching rt is not a hazard.
        ID_EX_MemRead = 1'b1; ID_EX_RegRt = 5'd7; IF_ID_RegRs = 5'd3; IF_ID_RegRt = 5'd7;
        IF_ID_UseRt = 1'b0;
        #1;
        check("ori_no_use_rt_ctl", ctl(), CTL_RUN);
        step();

        // jr $4 with a load to $4 in MEM: single stall, no EXT.
        idle_inputs();
        IDControl_Jr = 1'b1; IF_ID_RegRs = 5'd4; EX_MEM_MemRead = 1'b1; EX_MEM_RegRd = 5'd4;
        #1;
        check("jr_load_mem_ctl", ctl(), CTL_STALL);
        step();
        EX_MEM_MemRead = 1'b0; EX_MEM_RegRd = 5'd0;
        #1;
        check("jr_after_ctl", ctl(), CTL_FLUSH);
        step();

        // Reset asserted while in EXT.
        idle_inputs();
        ID_EX_MemRead = 1'b1; ID_EX_RegRt = 5'd8; IF_ID_RegRs = 5'd8; IDControl_Branch = 1'b1;
        step();
        idle_inputs();
        #1;
        check("ext_before_reset_ctl", ctl(), CTL_STALL);
        reset = 1'b0;
        #1;
        check("ext_reset_ctl", ctl(), CTL_RESET);
        check("ext_reset_stall_cnt", 32'(Stall_Count), 32'd0);
        step();
        reset = 1'b1;
        step();
        #1;
        check("post_reset_ctl", ctl(), CTL_RUN);
        check("post_reset_stall_cnt", 32'(Stall_Count), 32'd0);

        // Five load-use stalls: 2-bit counter saturates at 3.
        clear_counters();
        ID_EX_MemRead = 1'b1; ID_EX_RegRt = 5'd8; IF_ID_RegRs = 5'd8;
        for (int i = 0; i < 5; i++) step();
        idle_inputs();
        #1;
        check("sat_wide_stall_cnt", 32'(Stall_Count), 32'd5);
        check("sat_narrow_stall_cnt", 32'(Stall_Count2), 32'd3);

        // Clear in the same cycle as a stall wins.
        ID_EX_MemRead = 1'b1; ID_EX_RegRt = 5'd8; IF_ID_RegRs = 5'd8; Cnt_Clear = 1'b1;
        step();
        idle_inputs();
        #1;
        check("clear_prio_stall_cnt", 32'(Stall_Count), 32'd0);
        check("clear_prio_narrow_cnt", 32'(Stall_Count2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
